// File: rtl/otter_pkg.sv
// Shared OTTER control constants: opcodes, funct3 codes and the sequencer state type.
// Imported by both the control-unit FSM and the combinational decoder.
package otter_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

  typedef enum logic [2:0] {
    INIT,
    FETCH,
    EXEC,
    WB,
    INTR
  } cu_state_t;

  // Opcodes that retire in EXEC with a register-file writeback.
  function automatic logic is_rd_write_op(input logic [6:0] op);
    return (op == OP) || (op == OP_IMM) || (op == LUI) ||
           (op == AUIPC) || (op == JAL) || (op == JALR);
  endfunction

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: instruction fields and status in, datapath enables out.
// master = control unit, slave = datapath side.
interface otter_cu_fsm_if;

  logic [6:0] ir6_0;
  logic [2:0] ir14_12;
  logic       mem_ready;
  logic       intr;
  logic       mie;
  logic       pc_write;
  logic       reg_write;
  logic       mem_we2;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       rf_reset;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;
  logic       mem_timeout;

  modport master (
    input  ir6_0, ir14_12, mem_ready, intr, mie,
    output pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
           rf_reset, csr_we, int_taken, mret_exec, mem_timeout
  );

  modport slave (
    output ir6_0, ir14_12, mem_ready, intr, mie,
    input  pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
           rf_reset, csr_we, int_taken, mret_exec, mem_timeout
  );

endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle sequencer: steps INIT/FETCH/EXEC/WB/INTR and issues commit enables.
// Interrupt/CSR support is built only when OTTER_INTR_EN is defined.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic           CLK,
  input  logic           RST,
  otter_cu_fsm_if.master bus
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  cu_state_t         r_state;
  logic [INIT_W-1:0] r_init_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_intr_pend;

  cu_state_t         w_next_state;
  logic [INIT_W-1:0] w_init_cnt_nxt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              w_intr_pend_nxt;
  logic              w_instr_end;

`ifndef OTTER_INTR_EN
  logic w_unused;
  assign w_unused = &{1'b0, bus.intr, bus.mie, bus.ir14_12};
`endif

  always_comb begin
    w_next_state    = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_intr_pend_nxt = r_intr_pend;
    w_instr_end     = 1'b0;
    bus.pc_write    = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_we2     = 1'b0;
    bus.mem_rden1   = 1'b0;
    bus.mem_rden2   = 1'b0;
    bus.rf_reset    = 1'b0;
    bus.csr_we      = 1'b0;
    bus.int_taken   = 1'b0;
    bus.mret_exec   = 1'b0;
    bus.mem_timeout = 1'b0;

    unique case (r_state)
      INIT: begin
        bus.rf_reset = 1'b1;
        if (r_init_cnt == INIT_W'(INIT_CYCLES - 1)) w_next_state = FETCH;
        else w_init_cnt_nxt = r_init_cnt + INIT_W'(1);
      end
      FETCH: begin
        bus.mem_rden1 = 1'b1;
        w_next_state  = EXEC;
      end
      EXEC: begin
        if (bus.ir6_0 == LOAD) begin
          bus.mem_rden2  = 1'b1;
          w_next_state   = WB;
          w_wait_cnt_nxt = '0;
        end else begin
          w_instr_end  = 1'b1;
          bus.pc_write = 1'b1;
          if (bus.ir6_0 == STORE) bus.mem_we2 = 1'b1;
          else if (is_rd_write_op(bus.ir6_0)) bus.reg_write = 1'b1;
`ifdef OTTER_INTR_EN
          else if (bus.ir6_0 == SYSTEM) begin
            if (bus.ir14_12 == F3_MRET) bus.mret_exec = 1'b1;
            else if (bus.ir14_12 == F3_CSRRW) begin
              bus.csr_we    = 1'b1;
              bus.reg_write = 1'b1;
            end
          end
`endif
        end
      end
      WB: begin
        if (bus.mem_ready) begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          w_instr_end   = 1'b1;
        end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          // Give up on the load: advance the PC but never write stale data.
          bus.pc_write    = 1'b1;
          bus.mem_timeout = 1'b1;
          w_instr_end     = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      INTR: begin
        bus.int_taken = 1'b1;
        bus.pc_write  = 1'b1;
        w_next_state  = FETCH;
      end
      default: w_next_state = INIT;
    endcase

`ifdef OTTER_INTR_EN
    if (w_instr_end) w_next_state = (r_intr_pend && bus.mie) ? INTR : FETCH;
    // A request arriving during entry stays pending for the next boundary.
    if (r_state == INTR) w_intr_pend_nxt = bus.intr;
    else if (r_state != INIT) w_intr_pend_nxt = r_intr_pend | bus.intr;
`else
    if (w_instr_end) w_next_state = FETCH;
    w_intr_pend_nxt = 1'b0;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= INIT;
      r_init_cnt  <= '0;
      r_wait_cnt  <= '0;
      r_intr_pend <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_init_cnt  <= w_init_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_intr_pend <= w_intr_pend_nxt;
    end
  end

endmodule
